rej_ntt_poly_sampler: RTL

//  Algorithm 30 (RejNTTPoly), FIPS 204: samples one NTT-domain polynomial in T_q by rejection sampling.

---
 rtl/rej_ntt_poly_sampler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rej_ntt_poly_sampler.sv
// Purpose: RejNTTPoly rejection sampler; turns a SHAKE128 byte stream seeded by rho into N coefficients < Q.
// Latency: start -> xof_start 2 cycles; last coefficient write -> done 1 cycle; 3 bytes evaluated per cycle.
// Backpressure: xof_ready only while fewer than 3 bytes are buffered; unaccepted XOF words are simply held by the source.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start / rho       1-cycle start pulse and 34-byte seed (byte 32 = column l, byte 33 = row k)
//   done              1-cycle pulse once all N coefficients have been written
//   xof_start/_seed   absorb request to the XOF core with a registered copy of rho
//   xof_stop          abandon the current squeeze (issued together with done)
//   xof_valid/_ready  squeeze word handshake, xof_data byte 0 = [7:0] is earliest in the stream
//   coeff_we/_addr/_wdata  registered poly RAM write port
module rej_ntt_poly_sampler #(
    parameter int REJ_NTT_POLY_SEED = 272,
    parameter int N                 = 256,
    parameter int COEFF_WIDTH       = 24,
    parameter int Q                 = 8380417,
    parameter int DATA_IN_BITS      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [REJ_NTT_POLY_SEED-1:0] rho,
    output logic                         done,
    output logic                         xof_start,
    output logic [REJ_NTT_POLY_SEED-1:0] xof_seed,
    output logic                         xof_stop,
    input  logic                         xof_valid,
    input  logic [DATA_IN_BITS-1:0]      xof_data,
    output logic                         xof_ready,
    output logic                         coeff_we,
    output logic [7:0]                   coeff_addr,
    output logic [COEFF_WIDTH-1:0]       coeff_wdata
);

    localparam int BYTES_IN = DATA_IN_BITS / 8;
    // Up to 2 leftover bytes plus one full word.
    localparam int BUF_W    = DATA_IN_BITS + 16;
    localparam int CNT_W    = $clog2(BYTES_IN + 3);
    localparam logic [23:0] Q_L    = 24'(Q);
    localparam logic [7:0]  LAST_J = 8'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    state_t                         state_q, state_d;
    logic [BUF_W-1:0]               byte_buf_q, byte_buf_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [7:0]                     j_q, j_d;
    logic [REJ_NTT_POLY_SEED-1:0]   xof_seed_q, xof_seed_d;
    logic                           xof_start_q, xof_start_d;
    logic                           xof_stop_q, xof_stop_d;
    logic                           done_q, done_d;
    logic                           coeff_we_q, coeff_we_d;
    logic [7:0]                     coeff_addr_q, coeff_addr_d;
    logic [COEFF_WIDTH-1:0]         coeff_wdata_q, coeff_wdata_d;

    logic                           have_cand;
    logic [23:0]                    cand;
    logic [BUF_W-1:0]               word_ext;

    // Candidate always comes from the 3 oldest bytes; bit 23 (MSB of b2) is dropped.
    assign have_cand = (cnt_q >= CNT_W'(3));
    assign cand      = {1'b0, byte_buf_q[22:0]};
    // New word lands directly above the bytes already held.
    assign word_ext  = BUF_W'(xof_data) << {cnt_q, 3'b000};

    assign xof_ready   = (state_q == ST_SAMPLE) && !have_cand;
    assign done        = done_q;
    assign xof_start   = xof_start_q;
    assign xof_seed    = xof_seed_q;
    assign xof_stop    = xof_stop_q;
    assign coeff_we    = coeff_we_q;
    assign coeff_addr  = coeff_addr_q;
    assign coeff_wdata = coeff_wdata_q;

    always_comb begin
        state_d       = state_q;
        byte_buf_d    = byte_buf_q;
        cnt_d         = cnt_q;
        j_d           = j_q;
        xof_seed_d    = xof_seed_q;
        xof_start_d   = 1'b0;
        xof_stop_d    = 1'b0;
        done_d        = 1'b0;
        coeff_we_d    = 1'b0;
        coeff_addr_d  = coeff_addr_q;
        coeff_wdata_d = coeff_wdata_q;

        if (start) begin
            // A restart abandons whatever run is in flight, including a pending done.
            xof_seed_d = rho;
            byte_buf_d = '0;
            cnt_d      = '0;
            j_d        = '0;
            state_d    = ST_SEED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SEED: begin
                    xof_start_d = 1'b1;
                    state_d     = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (!have_cand) begin
                        if (xof_valid) begin
                            byte_buf_d = byte_buf_q | word_ext;
                            cnt_d      = cnt_q + CNT_W'(BYTES_IN);
                        end
                    end else begin
                        // Bytes are consumed whether or not the candidate is kept.
                        byte_buf_d = byte_buf_q >> 24;
                        cnt_d      = cnt_q - CNT_W'(3);
                        if (cand < Q_L) begin
                            coeff_we_d    = 1'b1;
                            coeff_addr_d  = j_q;
                            coeff_wdata_d = COEFF_WIDTH'(cand);
                            j_d           = j_q + 8'd1;
                            if (j_q == LAST_J) begin
                                state_d = ST_FINISH;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    done_d     = 1'b1;
                    xof_stop_d = 1'b1;
                    byte_buf_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byte_buf_q    <= '0;
            cnt_q         <= '0;
            j_q           <= '0;
            xof_seed_q    <= '0;
            xof_start_q   <= 1'b0;
            xof_stop_q    <= 1'b0;
            done_q        <= 1'b0;
            coeff_we_q    <= 1'b0;
            coeff_addr_q  <= '0;
            coeff_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_buf_q    <= byte_buf_d;
            cnt_q         <= cnt_d;
            j_q           <= j_d;
            xof_seed_q    <= xof_seed_d;
            xof_start_q   <= xof_start_d;
            xof_stop_q    <= xof_stop_d;
            done_q        <= done_d;
            coeff_we_q    <= coeff_we_d;
            coeff_addr_q  <= coeff_addr_d;
            coeff_wdata_q <= coeff_wdata_d;
        end
    end

endmodule
